// File: rtl/alu_result_checker_if.sv
// alu_result_checker_if
// Bundles the signals between the ALU test harness and the result checker.
//   start/stop            : run control pulses (harness -> checker)
//   in_valid/input_a/b/op : vector snooped as it is issued to the ALU
//   alu_out               : ALU result, LATENCY cycles after issue
//   busy/done             : run status
//   check/err/skip_count  : saturating run statistics
//   fail_*                : snapshot of the first mismatch of the run
// master = harness side, slave = checker side.
interface alu_result_checker_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             stop;
    logic             in_valid;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [3:0]       op;
    logic [WIDTH-1:0] alu_out;
    logic             busy;
    logic             done;
    logic [15:0]      check_count;
    logic [15:0]      err_count;
    logic [15:0]      skip_count;
    logic             fail_valid;
    logic [3:0]       fail_op;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    logic [WIDTH-1:0] fail_expected;
    logic [WIDTH-1:0] fail_actual;

    modport master (
        output start, stop, in_valid, input_a, input_b, op, alu_out,
        input  busy, done, check_count, err_count, skip_count,
               fail_valid, fail_op, fail_a, fail_b, fail_expected, fail_actual
    );

    modport slave (
        input  start, stop, in_valid, input_a, input_b, op, alu_out,
        output busy, done, check_count, err_count, skip_count,
               fail_valid, fail_op, fail_a, fail_b, fail_expected, fail_actual
    );
endinterface

// File: rtl/alu_result_checker.sv
// alu_result_checker
// Snoops vectors issued to the ALU, computes the expected result, delays it
// LATENCY cycles and compares it against alu_out. Keeps saturating
// check/error/skip counters and captures the first mismatch of a run.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : alu_result_checker_if.slave (control, snooped vector, status)
// Parameters: WIDTH (operand width), LATENCY (1..8, issue to alu_out).
// Optional: define ALU_CHECK_EXT_OPS_EN to also check op 4 (a^b) and
// op 5 (~a); otherwise they are counted as skipped.
module alu_result_checker #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    alu_result_checker_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | capturing and checking vectors
    // DRAIN | no new vectors; in-flight entries still compared
    // DONE  | run finished, results held
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_chk;
    logic [3:0]         r_op  [LATENCY];
    logic [WIDTH-1:0]   r_a   [LATENCY];
    logic [WIDTH-1:0]   r_b   [LATENCY];
    logic [WIDTH-1:0]   r_exp [LATENCY];

    logic [15:0]      r_check_count;
    logic [15:0]      r_err_count;
    logic [15:0]      r_skip_count;
    logic             r_fail_valid;
    logic [3:0]       r_fail_op;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic [WIDTH-1:0] r_fail_expected;
    logic [WIDTH-1:0] r_fail_actual;

    logic             w_chk;
    logic [WIDTH-1:0] w_exp;
    logic             w_capture;
    logic             w_pending;
    logic             w_exit_vld;
    logic             w_exit_chk;
    logic             w_mismatch;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        w_exp = '0;
        w_chk = 1'b1;
        case (bus.op)
            4'd0: w_exp = bus.input_a + bus.input_b;
            4'd1: w_exp = bus.input_a - bus.input_b;
            4'd2: w_exp = bus.input_a & bus.input_b;
            4'd3: w_exp = bus.input_a | bus.input_b;
`ifdef ALU_CHECK_EXT_OPS_EN
            4'd4: w_exp = bus.input_a ^ bus.input_b;
            4'd5: w_exp = ~bus.input_a;
`endif
            default: w_chk = 1'b0;
        endcase
    end

    assign w_capture  = (r_state == RUN) && bus.in_valid;
    assign w_exit_vld = r_vld[LATENCY-1];
    assign w_exit_chk = r_chk[LATENCY-1];
    assign w_mismatch = (bus.alu_out != r_exp[LATENCY-1]);

    // Entries that will still be in flight after this edge; the exiting
    // stage is excluded because it is being retired in this cycle.
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            w_pending = w_pending | r_vld[i];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (bus.start) w_state_next = RUN;
            RUN:   if (bus.start) w_state_next = RUN;
                   else if (bus.stop) w_state_next = DRAIN;
            DRAIN: if (bus.start) w_state_next = RUN;
                   else if (!w_pending) w_state_next = DONE;
            DONE:  if (bus.start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_vld   <= '0;
        end else begin
            r_state <= w_state_next;
            if (bus.start) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_capture;
                for (int i = 1; i < LATENCY; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
        end
    end

    // Payload only matters alongside its valid bit, so it needs no reset.
    always_ff @(posedge clock) begin
        r_chk[0] <= w_chk;
        r_op[0]  <= bus.op;
        r_a[0]   <= bus.input_a;
        r_b[0]   <= bus.input_b;
        r_exp[0] <= w_exp;
        for (int i = 1; i < LATENCY; i++) begin
            r_chk[i] <= r_chk[i-1];
            r_op[i]  <= r_op[i-1];
            r_a[i]   <= r_a[i-1];
            r_b[i]   <= r_b[i-1];
            r_exp[i] <= r_exp[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_check_count   <= '0;
            r_err_count     <= '0;
            r_skip_count    <= '0;
            r_fail_valid    <= 1'b0;
            r_fail_op       <= '0;
            r_fail_a        <= '0;
            r_fail_b        <= '0;
            r_fail_expected <= '0;
            r_fail_actual   <= '0;
        end else if (bus.start) begin
            r_check_count   <= '0;
            r_err_count     <= '0;
            r_skip_count    <= '0;
            r_fail_valid    <= 1'b0;
            r_fail_op       <= '0;
            r_fail_a        <= '0;
            r_fail_b        <= '0;
            r_fail_expected <= '0;
            r_fail_actual   <= '0;
        end else if (w_exit_vld) begin
            if (w_exit_chk) begin
                r_check_count <= sat_inc(r_check_count);
                if (w_mismatch) begin
                    r_err_count <= sat_inc(r_err_count);
                    if (!r_fail_valid) begin
                        r_fail_valid    <= 1'b1;
                        r_fail_op       <= r_op[LATENCY-1];
                        r_fail_a        <= r_a[LATENCY-1];
                        r_fail_b        <= r_b[LATENCY-1];
                        r_fail_expected <= r_exp[LATENCY-1];
                        r_fail_actual   <= bus.alu_out;
                    end
                end
            end else begin
                r_skip_count <= sat_inc(r_skip_count);
            end
        end
    end

    assign bus.busy          = (r_state == RUN) || (r_state == DRAIN);
    assign bus.done          = (r_state == DONE);
    assign bus.check_count   = r_check_count;
    assign bus.err_count     = r_err_count;
    assign bus.skip_count    = r_skip_count;
    assign bus.fail_valid    = r_fail_valid;
    assign bus.fail_op       = r_fail_op;
    assign bus.fail_a        = r_fail_a;
    assign bus.fail_b        = r_fail_b;
    assign bus.fail_expected = r_fail_expected;
    assign bus.fail_actual   = r_fail_actual;
endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;
    localparam int LAT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_result_checker_if #(.WIDTH(16)) bus ();

    alu_result_checker #(.WIDTH(16), .LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_printed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            if (n_printed < 40) begin
                n_printed++;
                $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
            end
        end
    endtask

    // Expected ALU behaviour: {checked, result}
    function automatic logic [16:0] gold(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (o)
            4'd0: begin r = a + b; return {1'b1, r}; end
            4'd1: begin r = a - b; return {1'b1, r}; end
            4'd2: return {1'b1, a & b};
            4'd3: return {1'b1, a | b};
`ifdef ALU_CHECK_EXT_OPS_EN
            4'd4: return {1'b1, a ^ b};
            4'd5: return {1'b1, ~a};
`endif
            default: return {1'b0, 16'h0000};
        endcase
    endfunction

    // Fake ALU: returns tb_actual for each issued vector LAT cycles later.
    logic [15:0] tb_actual = 16'h0;
    logic [15:0] alu_dly [LAT];
    always @(posedge clock) begin
        for (int i = LAT - 1; i > 0; i--) alu_dly[i] <= alu_dly[i-1];
        alu_dly[0] <= tb_actual;
    end
    assign bus.alu_out = alu_dly[LAT-1];

    // Behavioural model: queue of in-flight vectors each due at a given edge.
    typedef struct {
        int          due;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] act;
    } ent_t;

    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
    ent_t q[$];
    ent_t e;
    int edge_no = 0;
    int m_st = M_IDLE;
    logic [15:0] m_chk, m_err, m_skip;
    logic        m_fv;
    logic [3:0]  m_fop;
    logic [15:0] m_fa, m_fb, m_fe, m_fact;
    logic [16:0] g;

    task automatic m_clear();
        m_chk = 0; m_err = 0; m_skip = 0;
        m_fv = 0; m_fop = 0; m_fa = 0; m_fb = 0; m_fe = 0; m_fact = 0;
        q.delete();
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_clear();
            m_st = M_IDLE;
        end else begin
            edge_no++;
            if (bus.start) begin
                m_clear();
                m_st = M_RUN;
            end else begin
                while (q.size() > 0 && q[0].due == edge_no) begin
                    e = q.pop_front();
                    g = gold(e.op, e.a, e.b);
                    if (g[16]) begin
                        if (m_chk != 16'hFFFF) m_chk++;
                        if (e.act != g[15:0]) begin
                            if (m_err != 16'hFFFF) m_err++;
                            if (!m_fv) begin
                                m_fv = 1; m_fop = e.op; m_fa = e.a; m_fb = e.b;
                                m_fe = g[15:0]; m_fact = e.act;
                            end
                        end
                    end else if (m_skip != 16'hFFFF) begin
                        m_skip++;
                    end
                end
                case (m_st)
                    M_RUN: begin
                        if (bus.in_valid) begin
                            e.due = edge_no + LAT; e.op = bus.op; e.a = bus.input_a;
                            e.b = bus.input_b; e.act = tb_actual;
                            q.push_back(e);
                        end
                        if (bus.stop) m_st = M_DRAIN;
                    end
                    M_DRAIN: if (q.size() == 0) m_st = M_DONE;
                    default: ;
                endcase
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clock) begin
        chk("busy", bus.busy, (m_st == M_RUN || m_st == M_DRAIN));
        chk("done", bus.done, (m_st == M_DONE));
        chk("check_count", bus.check_count, m_chk);
        chk("err_count", bus.err_count, m_err);
        chk("skip_count", bus.skip_count, m_skip);
        chk("fail_valid", bus.fail_valid, m_fv);
        chk("fail_op", bus.fail_op, m_fop);
        chk("fail_a", bus.fail_a, m_fa);
        chk("fail_b", bus.fail_b, m_fb);
        chk("fail_expected", bus.fail_expected, m_fe);
        chk("fail_actual", bus.fail_actual, m_fact);
    end

    task automatic step(input logic s, input logic p, input logic v, input logic [3:0] o,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] act);
        @(negedge clock);
        bus.start = s; bus.stop = p; bus.in_valid = v; bus.op = o;
        bus.input_a = a; bus.input_b = b; tb_actual = act;
    endtask

    task automatic vec(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] act);
        step(0, 0, 1, o, a, b, act);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pstart();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic stop_and_wait(input string name);
        int k;
        step(0, 1, 0, 0, 0, 0, 0);
        k = 0;
        while (!bus.done && k < LAT + 2) begin
            step(0, 0, 0, 0, 0, 0, 0);
            k++;
        end
        chk({name, "_done"}, bus.done, 1'b1);
        chk({name, "_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.in_valid = 0; bus.op = 0;
        bus.input_a = 0; bus.input_b = 0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err_count, 16'h0);
        chk("rst_fail_valid", bus.fail_valid, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Adds, all correct; stop right after the last vector
        pstart();
        vec(0, 16'h0000, 16'h0000, 16'h0000);
        vec(0, 16'h0001, 16'h0000, 16'h0001);
        vec(0, 16'h0001, 16'h0001, 16'h0002);
        stop_and_wait("add_stop");
        chk("add_check", bus.check_count, 16'd3);
        chk("add_err", bus.err_count, 16'd0);
        chk("add_skip", bus.skip_count, 16'd0);

        // Subtract: wrap to all-ones is correct, forced 1 for 5-3 is an error
        pstart();
        vec(1, 16'h0000, 16'h0001, 16'hFFFF);
        vec(1, 16'h0005, 16'h0003, 16'h0001);
        idle(LAT + 2);
        chk("sub_check", bus.check_count, 16'd2);
        chk("sub_err", bus.err_count, 16'd1);
        chk("sub_fail_valid", bus.fail_valid, 1'b1);
        chk("sub_fail_op", bus.fail_op, 4'd1);
        chk("sub_fail_a", bus.fail_a, 16'd5);
        chk("sub_fail_b", bus.fail_b, 16'd3);
        chk("sub_fail_exp", bus.fail_expected, 16'd2);
        chk("sub_fail_act", bus.fail_actual, 16'd1);

        // Two consecutive OR errors: first one stays captured
        pstart();
        vec(3, 16'h0000, 16'h0001, 16'h0000);
        vec(3, 16'h0001, 16'h0001, 16'h0000);
        idle(LAT + 2);
        chk("or_err", bus.err_count, 16'd2);
        chk("or_fail_exp", bus.fail_expected, 16'd1);
        chk("or_fail_a", bus.fail_a, 16'd0);
        chk("or_fail_b", bus.fail_b, 16'd1);

        // AND with an unchecked opcode in between, then op 4
        pstart();
        vec(2, 16'h0001, 16'h0000, 16'h0000);
        vec(7, 16'h0003, 16'h0003, 16'h1234);
        vec(2, 16'h0001, 16'h0001, 16'h0001);
        idle(LAT + 2);
        chk("and_check", bus.check_count, 16'd2);
        chk("and_skip", bus.skip_count, 16'd1);
        vec(4, 16'hF0F0, 16'h0FF0, 16'hFF00);
        vec(5, 16'h00FF, 16'h0000, 16'hFF00);
        idle(LAT + 2);
`ifdef ALU_CHECK_EXT_OPS_EN
        chk("ext_check", bus.check_count, 16'd4);
        chk("ext_skip", bus.skip_count, 16'd1);
`else
        chk("ext_check", bus.check_count, 16'd2);
        chk("ext_skip", bus.skip_count, 16'd3);
`endif
        chk("ext_err", bus.err_count, 16'd0);
        stop_and_wait("ext_stop");

        // Restart while running; start+stop together stays in RUN
        pstart();
        for (int i = 0; i < 5; i++) vec(0, 16'(i), 16'(2 * i), 16'(3 * i));
        idle(LAT + 2);
        chk("restart_pre", bus.check_count, 16'd5);
        pstart();
        idle(1);
        chk("restart_clr", bus.check_count, 16'd0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(1);
        chk("start_stop_busy", bus.busy, 1'b1);
        chk("start_stop_done", bus.done, 1'b0);

        // Reset with three vectors in flight
        pstart();
        vec(0, 16'h0010, 16'h0001, 16'h0000);
        vec(1, 16'h0010, 16'h0001, 16'h0000);
        vec(2, 16'h0010, 16'h0001, 16'h0000);
        bus.in_valid = 0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_check", bus.check_count, 16'd0);
        chk("rst_mid_err", bus.err_count, 16'd0);
        chk("rst_mid_fail_valid", bus.fail_valid, 1'b0);
        idle(2);
        reset = 1'b0;
        idle(LAT + 3);
        chk("rst_after_check", bus.check_count, 16'd0);
        chk("rst_after_err", bus.err_count, 16'd0);
        chk("rst_after_skip", bus.skip_count, 16'd0);

        // Always-wrong ALU: counters saturate
        pstart();
        for (int i = 0; i < 70000; i++) begin
            logic [15:0] a16;
            a16 = 16'(i);
            vec(0, a16, 16'h0000, a16 + 16'd1);
        end
        idle(LAT + 2);
        chk("sat_err", bus.err_count, 16'hFFFF);
        chk("sat_check", bus.check_count, 16'hFFFF);
        chk("sat_fail_a", bus.fail_a, 16'h0000);
        chk("sat_fail_act", bus.fail_actual, 16'h0001);
        stop_and_wait("sat_stop");

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
